// File: rtl/snn_mem_pkg.sv
// Shared definitions for the SNN memory arbiter: default widths, bank map,
// the read-tag payload and the bank-mapping helper.
package snn_mem_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned ID_W   = 3;

    // Bank codes live in addr[15:12]; 8, D and F are unmapped holes.
    localparam logic [3:0] BANK_CFG     = 4'h0;
    localparam logic [3:0] BANK_FWD_LO  = 4'h1;
    localparam logic [3:0] BANK_FWD_HI  = 4'h2;
    localparam logic [3:0] BANK_TGT     = 4'h3;
    localparam logic [3:0] BANK_WGT_LO  = 4'h4;
    localparam logic [3:0] BANK_WGT_HI  = 4'h7;
    localparam logic [3:0] BANK_GRAD_LO = 4'h9;
    localparam logic [3:0] BANK_GRAD_HI = 4'hC;
    localparam logic [3:0] BANK_STATE   = 4'hE;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } tag_t;

    // True when the address falls in one of the populated banks.
    function automatic logic bank_mapped(input logic [15:0] addr);
        logic [3:0] bank;
        bank = addr[15:12];
        return (bank == BANK_CFG)
            || ((bank >= BANK_FWD_LO)  && (bank <= BANK_FWD_HI))
            || (bank == BANK_TGT)
            || ((bank >= BANK_WGT_LO)  && (bank <= BANK_WGT_HI))
            || ((bank >= BANK_GRAD_LO) && (bank <= BANK_GRAD_HI))
            || (bank == BANK_STATE);
    endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// Combinational round-robin picker: search starts after ptr and wraps;
// while lock is high the owner (ptr) keeps the grant.
module snn_rr_arbiter
    import snn_mem_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             lock,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner
);

    logic found;

    // First valid requester at distance 1..N_REQ from ptr, owner first when locked.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        if (lock) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (ID_W'(i) == ptr) begin
                    grant[i] = req[i];
                    winner   = ptr;
                    found    = 1'b1;
                end
            end
        end
        for (int k = 1; k <= int'(N_REQ); k++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % int'(N_REQ)))) begin
                    grant[i] = 1'b1;
                    winner   = ID_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/snn_mem_arbiter.sv
// Round-robin arbiter sharing the single-port SNN memory controller between
// N_REQ requesters, with an in-order read-tag pipeline for response routing.
// Optional macro ARB_LOCK_EN adds req_lock for atomic read-modify-write.
module snn_mem_arbiter
    import snn_mem_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]    req_lock,
`endif
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                rsp_err,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int unsigned DEPTH = MEM_LAT + 1;

    logic [ID_W-1:0]  ptr;
    logic             lock;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  winner;
    logic             hs;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_mapped;
    tag_t             tag_q [DEPTH];
    tag_t             tail;

`ifdef ARB_LOCK_EN
    logic owner_vld;

    // Owner keeps the bus while it holds both lock and valid.
    always_comb begin
        lock = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ID_W'(i) == ptr) lock = owner_vld & req_lock[i] & req_valid[i];
        end
    end

    // Remember that a real owner exists (the reset pointer is not an owner).
    always_ff @(posedge clk) begin
        if (rst)     owner_vld <= 1'b0;
        else if (hs) owner_vld <= 1'b1;
    end
`else
    assign lock = 1'b0;
`endif

    snn_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .lock   (lock),
        .grant  (grant),
        .winner (winner)
    );

    assign req_ready  = grant;
    assign hs         = |grant;
    assign sel_mapped = bank_mapped(16'(sel_addr));
    assign tail       = tag_q[DEPTH-1];

    // Mux the winning requester's payload.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Register the accepted access towards memory and advance the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= ID_W'(N_REQ - 1);
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= hs & sel_we & sel_mapped;
            if (hs) begin
                ptr       <= winner;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Tag pipeline aligned with the memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < int'(DEPTH); d++) tag_q[d] <= '0;
        end else begin
            tag_q[0].valid <= hs & ~sel_we;
            tag_q[0].id    <= winner;
            tag_q[0].err   <= ~sel_mapped;
            for (int d = 1; d < int'(DEPTH); d++) tag_q[d] <= tag_q[d-1];
        end
    end

    // Capture read data and route the one-cycle strobe to the issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                rsp_valid[i] <= tail.valid && (tail.id == ID_W'(i));
            end
            rsp_err   <= tail.valid & tail.err;
            rsp_rdata <= (tail.valid && !tail.err) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_snn_mem_arbiter.sv
// Self-checking bench for snn_mem_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level memory/arbitration model.
`timescale 1ns/1ps
module tb_snn_mem_arbiter;

    localparam int N   = 3;
    localparam int AWL = 16;
    localparam int DWL = 32;
    localparam int SZ  = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_we;
    logic [N*AWL-1:0] req_addr;
    logic [N*DWL-1:0] req_wdata;
`ifdef ARB_LOCK_EN
    logic [N-1:0]     req_lock;
`endif
    logic [N-1:0]     rsp_valid;
    logic [DWL-1:0]   rsp_rdata;
    logic             rsp_err;
    logic             mem_we;
    logic [AWL-1:0]   mem_addr;
    logic [DWL-1:0]   mem_wdata;
    logic [DWL-1:0]   mem_rdata;

    always #5 clk = ~clk;

    snn_mem_arbiter #(.N_REQ(N), .MEM_LAT(1), .AW(AWL), .DW(DWL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Word index over the address bits the bench exercises.
    function automatic logic [7:0] widx(input logic [15:0] a);
        return {a[15:12], a[5:2]};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return (i == 'h11) ? 32'hDEADBEEF : (32'hC0FFEE00 | 32'(i));
    endfunction

    function automatic bit unmapped(input logic [15:0] a);
        return (a[15:12] == 4'h8) || (a[15:12] == 4'hD) || (a[15:12] == 4'hF);
    endfunction

    // Stand-in BRAM with one cycle of read latency.
    logic [31:0] bram [0:255];
    logic        fill;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) bram[i] <= pat(i);
        end else if (mem_we) begin
            bram[widx(mem_addr)] <= mem_wdata;
        end
        mem_rdata <= bram[widx(mem_addr)];
    end

    // Reference model state.
    logic [31:0]  gold [0:255];
    int           cyc;
    int           mptr;
    bit           mown;
    logic         exp_we;
    logic [15:0]  exp_addr;
    logic [31:0]  exp_wd;
    logic [N-1:0] exp_rv [0:SZ-1];
    logic [31:0]  exp_rd [0:SZ-1];
    logic         exp_re [0:SZ-1];

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] last_grant;
    int           rsp_cnt [N];
    logic [31:0]  last_rd [N];
    logic         last_err [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected winner from the arbitration rules, -1 when nobody is valid.
    function automatic int model_winner(input logic [N-1:0] v, input logic [N-1:0] lk);
`ifdef ARB_LOCK_EN
        if (mown && lk[mptr] && v[mptr]) return mptr;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // One clock of traffic: drive, check at negedge, commit model at posedge.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w,
                         input logic [N*AWL-1:0] a, input logic [N*DWL-1:0] d,
                         input logic [N-1:0] lk);
        int           win;
        logic [N-1:0] one;
        logic [N-1:0] eg;
        logic [15:0]  wa;
        one       = 1;
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
`ifdef ARB_LOCK_EN
        req_lock  = lk;
`endif
        win = model_winner(v, lk);
        eg  = (win >= 0) ? (one << win) : '0;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv[cyc]));
        if (exp_rv[cyc] != '0) begin
            chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
            chk("rsp_err", 32'(rsp_err), 32'(exp_re[cyc]));
        end
        last_grant = req_ready;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                last_rd[i]  = rsp_rdata;
                last_err[i] = rsp_err;
            end
        end
        @(posedge clk);
        if (win >= 0) begin
            wa       = a[win*AWL +: AWL];
            exp_addr = wa;
            exp_wd   = d[win*DWL +: DWL];
            exp_we   = w[win] && !unmapped(wa);
            if (!w[win]) begin
                exp_rv[cyc+3] = one << win;
                exp_re[cyc+3] = unmapped(wa);
                exp_rd[cyc+3] = unmapped(wa) ? 32'h0 : gold[widx(wa)];
            end else if (!unmapped(wa)) begin
                gold[widx(wa)] = d[win*DWL +: DWL];
            end
            mptr = win;
            mown = 1'b1;
        end else begin
            exp_we = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, '0, '0);
    endtask

    // One reset cycle; requests offered during it must have no effect.
    task automatic do_reset(input logic [N-1:0] v, input logic [N*AWL-1:0] a);
        rst       = 1'b1;
        req_valid = v;
        req_we    = '0;
        req_addr  = a;
        req_wdata = '0;
`ifdef ARB_LOCK_EN
        req_lock  = '0;
`endif
        @(negedge clk);
        chk("rst_cycle_rsp_valid", 32'(rsp_valid), 32'(exp_rv[cyc]));
        @(posedge clk);
        for (int k = 1; k < 8; k++) begin
            if (cyc + k < SZ) begin
                exp_rv[cyc+k] = '0;
                exp_rd[cyc+k] = '0;
                exp_re[cyc+k] = 1'b0;
            end
        end
        mptr     = N - 1;
        mown     = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_wd   = '0;
        cyc++;
        #1;
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
        chk({tag, "_mem_we"},    32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            rsp_cnt[i]  = 0;
            last_rd[i]  = 'x;
            last_err[i] = 1'bx;
        end
    endtask

    initial begin
        logic [N-1:0]     one;
        logic [N-1:0]     v;
        logic [N-1:0]     w;
        logic [N-1:0]     lk;
        logic [N*AWL-1:0] a;
        logic [N*DWL-1:0] d;
        logic [3:0]       bank;
        logic [3:0]       off;

        one = 1;
        for (int i = 0; i < SZ; i++) begin
            exp_rv[i] = '0;
            exp_rd[i] = '0;
            exp_re[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) gold[i] = pat(i);
        cyc = 0;
        clear_counts();

        rst       = 1'b1;
        fill      = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef ARB_LOCK_EN
        req_lock  = '0;
`endif
        @(posedge clk);
        #1;
        fill = 1'b0;
        do_reset('0, '0);
        check_zero("reset");
        chk("reset_req_ready", 32'(req_ready), 32'h0);

        // Single read of the preloaded word.
        clear_counts();
        drive(3'b001, 3'b000, {16'h0, 16'h0, 16'h1004}, '0, '0);
        idle(4);
        chk("single_rsp_count", 32'(rsp_cnt[0]), 32'd1);
        chk("single_rsp_data", last_rd[0], 32'hDEADBEEF);

        // Fairness: everyone valid for nine cycles.
        do_reset('0, '0);
        clear_counts();
        for (int k = 0; k < 9; k++) begin
            drive(3'b111, 3'b000, {16'h2008, 16'h2004, 16'h2000}, '0, '0);
            chk("fair_grant", 32'(last_grant), 32'(one << (k % 3)));
        end
        idle(4);
        for (int i = 0; i < N; i++) chk("fair_rsp_count", 32'(rsp_cnt[i]), 32'd3);

        // Write then read of the same address on consecutive cycles.
        clear_counts();
        drive(3'b010, 3'b010, {16'h0, 16'h4010, 16'h0}, {32'h0, 32'h12345678, 32'h0}, '0);
        chk("wr_grant", 32'(last_grant), 32'b010);
        drive(3'b100, 3'b000, {16'h4010, 16'h0, 16'h0}, '0, '0);
        chk("rd_grant", 32'(last_grant), 32'b100);
        idle(4);
        chk("raw_data", last_rd[2], 32'h12345678);

        // Unmapped bank accesses.
        clear_counts();
        drive(3'b001, 3'b001, {16'h0, 16'h0, 16'h8000}, {64'h0, 32'hCAFEF00D}, '0);
        drive(3'b001, 3'b000, {16'h0, 16'h0, 16'hD000}, '0, '0);
        chk("unmapped_write_we", 32'(mem_we), 32'h0);
        idle(4);
        chk("unmapped_err", 32'(last_err[0]), 32'h1);
        chk("unmapped_data", last_rd[0], 32'h0);

        // Reset while three reads are in flight.
        drive(3'b001, 3'b000, {16'h0, 16'h0, 16'h3000}, '0, '0);
        drive(3'b010, 3'b000, {16'h0, 16'h3004, 16'h0}, '0, '0);
        do_reset(3'b100, {16'h3008, 16'h0, 16'h0});
        check_zero("midrst");
        clear_counts();
        idle(6);
        for (int i = 0; i < N; i++) chk("midrst_no_rsp", 32'(rsp_cnt[i]), 32'd0);

`ifdef ARB_LOCK_EN
        // Requester 2 locks the bus for four cycles.
        drive(3'b100, 3'b000, {16'h4000, 16'h0, 16'h0}, '0, 3'b100);
        chk("lock_take", 32'(last_grant), 32'b100);
        for (int k = 0; k < 4; k++) begin
            drive(3'b111, 3'b000, {16'h4004, 16'h1000, 16'h1004}, '0, 3'b100);
            chk("lock_hold", 32'(last_grant), 32'b100);
        end
        drive(3'b111, 3'b000, {16'h4004, 16'h1000, 16'h1004}, '0, 3'b000);
        chk("lock_release", 32'(last_grant), 32'b001);
        idle(4);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(N'($urandom_range(0, 7)), '0);
            v = N'($urandom_range(0, 7));
            w = N'($urandom_range(0, 7));
            lk = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                bank = 4'($urandom_range(0, 15));
                off  = 4'($urandom_range(0, 3));
                a[i*AWL +: AWL] = {bank, 6'b0, off, 2'b0};
                d[i*DWL +: DWL] = $urandom;
            end
            drive(v, w, a, d, lk);
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snn_mem_arbiter.md
Name: snn_mem_arbiter

Overview:
- Round-robin arbiter that shares the single-port SNN memory controller between N requesters: forward engine, gradient/learning engine, and host loader.
- Accepts one request per cycle and drives registered we/addr/wdata into the memory controller.
- Tracks in-flight reads through a tag pipeline and routes read data back to the requester that issued it.
- Flags accesses to unmapped banks (addr[15:12] = 8, D, F) without touching memory.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MEM_LAT, 1, cycles from mem_addr valid to mem_rdata valid (BRAM read latency).
- AW, 16, byte address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; combinational from grant
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*AW  packed byte addresses; requester i occupies [i*AW +: AW]
- req_wdata  in  N_REQ*DW  packed write data
- rsp_valid  out  N_REQ  one-hot read-response strobe
- rsp_rdata  out  DW  read data, shared by all requesters; qualified by rsp_valid
- rsp_err  out  1  unmapped-bank flag, qualified by any rsp_valid
- mem_we  out  1  to memory controller we
- mem_addr  out  AW  to memory controller addr
- mem_wdata  out  DW  to memory controller wdata
- mem_rdata  in  DW  from memory controller rdata

Behaviour:
- Reset values: all outputs 0, round-robin pointer = N_REQ-1 (requester 0 wins first), tag pipeline empty.
- Grant each cycle:
  - Search starts at pointer+1 and wraps modulo N_REQ; the first requester with req_valid wins.
  - req_ready is high only for the winner; a handshake is req_valid & req_ready.
  - The pointer updates to the winner on handshake only.
  - With no valid requester: no grant, pointer holds.
- Issue: on a handshake in cycle T, mem_addr/mem_wdata/mem_we are registered and presented during T+1.
- Idle cycles: mem_we = 0 and mem_addr holds its last value.
- Unmapped bank (addr[15:12] in {8, D, F}): mem_we forced 0 for writes; reads still go through the pipeline.
- Read response:
  - The tag pipeline is MEM_LAT+1 stages deep and carries {valid, requester id, err}.
  - mem_rdata is captured at T+1+MEM_LAT; rsp_valid[id] and rsp_rdata are registered and high for exactly one cycle at T+2+MEM_LAT (T+3 at default).
  - When err is set, rsp_rdata = 0 and rsp_err = 1.
- Writes produce no response.
- Ordering: strictly in order; a read issued after a write to the same address returns the new data.
- Throughput: one access per cycle, back-to-back, with no bubbles.
- rsp_valid is one-hot or all-zero in every cycle.
- req_* inputs are sampled only on a handshake; a requester may change or drop its request before acceptance.
- Reset mid-operation: in-flight tags are discarded, no rsp_valid is raised after rst, and mem_we = 0 in the cycle after rst.

Optional Feature:
- Macro ARB_LOCK_EN adds input port req_lock [N_REQ].
- With ARB_LOCK_EN:
  - While the current owner (last granted) holds req_lock and req_valid, it keeps the grant every cycle and all other req_ready stay 0.
  - Lock releases when req_lock or req_valid drops; normal round-robin resumes from the owner.
  - Intended for atomic read-modify-write of the weight bank.
- Without ARB_LOCK_EN: the port does not exist and arbitration is pure round-robin.

Decomposition:
- Package snn_mem_pkg holds:
  - AW/DW defaults;
  - bank code localparams (CFG = 0, FWD = 1..2, TGT = 3, WGT = 4..7, GRAD = 9..C, STATE = E);
  - function bank_mapped(addr);
  - the tag struct {valid, id, err}.
- One sub-module: snn_rr_arbiter.
  - Inputs: req vector, pointer, lock.
  - Outputs: one-hot grant and winner id.
  - Purely combinational; pointer register stays in the parent.

Test Plan:
- Reset then a single read: requester 0 reads 0x1004 (preloaded 0xDEADBEEF) -> mem_addr = 0x1004 at T+1, rsp_valid = 3'b001 and rsp_rdata = 0xDEADBEEF at T+3, one cycle only.
- Fairness: all 3 requesters hold req_valid for 9 cycles -> grants 0,1,2,0,1,2,0,1,2, and each receives 3 responses tagged to itself.
- Write then read: requester 1 writes 0x4010 = 0x12345678, requester 2 reads 0x4010 next cycle -> requester 2 gets 0x12345678, with no stall between the two accesses.
- Unmapped bank: requester 0 writes 0x8000 -> mem_we stays 0; requester 0 reads 0xD000 -> rsp_err = 1 and rsp_rdata = 0 at T+3.
- Reset during flight: 3 back-to-back reads, rst asserted at T+2 -> no rsp_valid in any later cycle, and all outputs 0 after rst.
- ARB_LOCK_EN: requester 2 locks for 4 cycles while 0 and 1 are valid -> only requester 2 is granted; after release the next grant goes to requester 0.
